// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared pcore types and constants for the IF stage
package fetch_unit_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

   typedef enum logic [3:0] {
      INSTR_MISALIGN   = 4'd0,
      INSTR_PAGE_FAULT = 4'd12
   } exc_code_t;

   typedef enum logic [6:0] {
      OPC_LOAD     = 7'b0000011,
      OPC_MISC_MEM = 7'b0001111,
      OPC_OP_IMM   = 7'b0010011,
      OPC_AUIPC    = 7'b0010111,
      OPC_STORE    = 7'b0100011,
      OPC_OP       = 7'b0110011,
      OPC_LUI      = 7'b0110111,
      OPC_BRANCH   = 7'b1100011,
      OPC_JALR     = 7'b1100111,
      OPC_JAL      = 7'b1101111,
      OPC_SYSTEM   = 7'b1110011
   } opcode_t;

   typedef struct packed {
      logic [XLEN-1:0] addr;
      logic            req;
      logic            req_kill;
      logic            icache_flush;
   } if2icache_t;

   typedef struct packed {
      logic [31:0] r_data;
      logic        ack;
   } icache2if_t;

   typedef struct packed {
      logic [XLEN-1:0] i_vaddr;
      logic            i_req;
   } if2mmu_t;

   typedef struct packed {
      logic [XLEN-1:0] i_paddr;
      logic            i_hit;
      logic            i_page_fault;
   } mmu2if_t;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_next;
      exc_code_t       exc_code;
   } if2id_data_t;

   typedef struct packed {
      logic exc_req;
      logic irq_req;
   } if2id_ctrl_t;

   typedef struct packed {
      logic [XLEN-1:0] pc_new;
   } exe2if_fb_t;

   typedef struct packed {
      logic [XLEN-1:0] pc_new;
      logic            irq_req;
      logic            icache_flush;
   } csr2if_fb_t;

   typedef struct packed {
      logic csr_new_pc_req;
      logic exe_new_pc_req;
      logic wfi_req;
      logic if_stall;
   } fwd2if_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - pcore RV32 instruction-fetch stage (PC sequencing, fetch request, fetch exceptions)
module fetch_unit #(
   parameter logic [fetch_unit_pkg::XLEN-1:0] RESET_PC = fetch_unit_pkg::RESET_PC
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output fetch_unit_pkg::if2icache_t   if2icache_o,
   input  fetch_unit_pkg::icache2if_t   icache2if_i,
   output fetch_unit_pkg::if2mmu_t      if2mmu_o,
   input  fetch_unit_pkg::mmu2if_t      mmu2if_i,
   output fetch_unit_pkg::if2id_data_t  if2id_data_o,
   output fetch_unit_pkg::if2id_ctrl_t  if2id_ctrl_o,
   input  fetch_unit_pkg::exe2if_fb_t   exe2if_fb_i,
   input  fetch_unit_pkg::csr2if_fb_t   csr2if_fb_i,
   input  fetch_unit_pkg::fwd2if_t      fwd2if_i
);
   import fetch_unit_pkg::*;

   logic [XLEN-1:0] pc_ff;
   logic [XLEN-1:0] pc_inc;
   logic            kill;
   logic            misalign;
   logic            exc_req;
   exc_code_t       exc_code;

   // Translation is resolved outside this stage; fetch never waits on the MMU hit
   logic unused_mmu;
   assign unused_mmu = ^{mmu2if_i.i_paddr, mmu2if_i.i_hit};

   assign pc_inc   = pc_ff + XLEN'(4);
   assign kill     = fwd2if_i.csr_new_pc_req | fwd2if_i.exe_new_pc_req;
   assign misalign = (pc_ff[1:0] != 2'b00);

   // PC register: redirects first (CSR over EXE), then hold conditions, else sequential +4
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_ff <= RESET_PC;
      end else if (fwd2if_i.csr_new_pc_req) begin
         pc_ff <= csr2if_fb_i.pc_new;
      end else if (fwd2if_i.exe_new_pc_req) begin
         pc_ff <= exe2if_fb_i.pc_new;
      end else if (fwd2if_i.wfi_req || fwd2if_i.if_stall || !icache2if_i.ack) begin
         pc_ff <= pc_ff;
      end else begin
         pc_ff <= pc_inc;
      end
   end

   // Fetch-side exception: misalignment outranks page fault; a redirect squashes both
   always_comb begin
      exc_req  = 1'b0;
      exc_code = INSTR_MISALIGN;
      if (misalign) begin
         exc_req = 1'b1;
      end else if (mmu2if_i.i_page_fault) begin
         exc_req  = 1'b1;
         exc_code = INSTR_PAGE_FAULT;
      end
      if (kill) begin
         exc_req = 1'b0;
      end
   end

   // Request, kill and pass-through outputs toward cache, MMU and decode
   always_comb begin
      if2icache_o.addr         = pc_ff;
      if2icache_o.req          = !misalign && !kill;
      if2icache_o.req_kill     = kill;
      if2icache_o.icache_flush = csr2if_fb_i.icache_flush;

      if2mmu_o.i_vaddr = pc_ff;
      if2mmu_o.i_req   = rst_n;

      if2id_data_o.pc       = pc_ff;
      if2id_data_o.pc_next  = pc_inc;
      if2id_data_o.exc_code = exc_code;
      if (icache2if_i.ack && !kill && !exc_req && !fwd2if_i.wfi_req) begin
         if2id_data_o.instr = icache2if_i.r_data;
      end else begin
         if2id_data_o.instr = INSTR_NOP;
      end

      if2id_ctrl_o.exc_req = exc_req;
      if2id_ctrl_o.irq_req = csr2if_fb_i.irq_req;
   end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with directed vectors
module tb_fetch_unit;
   import fetch_unit_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   if2icache_t  if2icache;
   icache2if_t  icache2if;
   if2mmu_t     if2mmu;
   mmu2if_t     mmu2if;
   if2id_data_t if2id_data;
   if2id_ctrl_t if2id_ctrl;
   exe2if_fb_t  exe2if_fb;
   csr2if_fb_t  csr2if_fb;
   fwd2if_t     fwd2if;

   fetch_unit dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .if2icache_o  (if2icache),
      .icache2if_i  (icache2if),
      .if2mmu_o     (if2mmu),
      .mmu2if_i     (mmu2if),
      .if2id_data_o (if2id_data),
      .if2id_ctrl_o (if2id_ctrl),
      .exe2if_fb_i  (exe2if_fb),
      .csr2if_fb_i  (csr2if_fb),
      .fwd2if_i     (fwd2if)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] pc;
      logic        exc;
      logic [3:0]  code;
      logic [31:0] instr;
      logic        req;
      logic        kill;
      logic        irq;
      logic        ireq;
      logic        flush;
   } exp_t;

   exp_t sb[$];
   int   n_total = 0;
   int   n_pass  = 0;
   int   cyc     = 0;

   task automatic chk(input int id, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL c%0d %s: got %h expected %h", id, name, act, exp);
   endtask

   // Monitor: every cycle presents a fetch result; compare it with the oldest expectation
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.id, "pc", if2id_data.pc, e.pc);
            chk(e.id, "pc_next", if2id_data.pc_next, e.pc + 32'd4);
            chk(e.id, "icache_addr", if2icache.addr, e.pc);
            chk(e.id, "mmu_vaddr", if2mmu.i_vaddr, e.pc);
            chk(e.id, "exc_req", 32'(if2id_ctrl.exc_req), 32'(e.exc));
            if (e.exc) chk(e.id, "exc_code", 32'(if2id_data.exc_code), 32'(e.code));
            chk(e.id, "instr", if2id_data.instr, e.instr);
            chk(e.id, "icache_req", 32'(if2icache.req), 32'(e.req));
            chk(e.id, "req_kill", 32'(if2icache.req_kill), 32'(e.kill));
            chk(e.id, "irq_req", 32'(if2id_ctrl.irq_req), 32'(e.irq));
            chk(e.id, "mmu_i_req", 32'(if2mmu.i_req), 32'(e.ireq));
            chk(e.id, "icache_flush", 32'(if2icache.icache_flush), 32'(e.flush));
         end
      end
   end

   task automatic drive(input bit r, input bit c, input bit e, input bit w, input bit s,
                        input bit a, input bit pf, input bit irq, input bit fl,
                        input logic [31:0] cpc, input logic [31:0] epc);
      @(posedge clk);
      #1;
      cyc++;
      rst_n                   = r;
      fwd2if.csr_new_pc_req   = c;
      fwd2if.exe_new_pc_req   = e;
      fwd2if.wfi_req          = w;
      fwd2if.if_stall         = s;
      icache2if.ack           = a;
      icache2if.r_data        = 32'hC0DE_0000 + 32'(cyc);
      mmu2if.i_page_fault     = pf;
      csr2if_fb.irq_req       = irq;
      csr2if_fb.icache_flush  = fl;
      csr2if_fb.pc_new        = cpc;
      exe2if_fb.pc_new        = epc;
   endtask

   task automatic expect_out(input logic [31:0] pc, input bit exc, input logic [3:0] code,
                             input bit nop, input bit req, input bit kill);
      exp_t x;
      x.id    = cyc;
      x.pc    = pc;
      x.exc   = exc;
      x.code  = code;
      x.instr = nop ? 32'h0000_0013 : icache2if.r_data;
      x.req   = req;
      x.kill  = kill;
      x.irq   = csr2if_fb.irq_req;
      x.ireq  = rst_n;
      x.flush = csr2if_fb.icache_flush;
      sb.push_back(x);
   endtask

   // Stimulus: drive(rst,csr,exe,wfi,stall,ack,pf,irq,flush,csr_pc,exe_pc); expect_out(pc,exc,code,nop,req,kill)
   initial begin
      icache2if  = '0;
      mmu2if     = '0;
      exe2if_fb  = '0;
      csr2if_fb  = '0;
      fwd2if     = '0;
      mmu2if.i_paddr = 32'h1234_5678;
      mmu2if.i_hit   = 1'b1;

      drive(0,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h00, 0, 4'd0,  0, 1, 0);
      drive(1,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h00, 0, 4'd0,  0, 1, 0);
      drive(1,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h04, 0, 4'd0,  0, 1, 0);
      drive(1,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h08, 0, 4'd0,  0, 1, 0);
      drive(1,1,0,0,0,1,0,0,0, 32'h2, 32'h0);   expect_out(32'h0C, 0, 4'd0,  1, 0, 1);
      drive(1,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h02, 1, 4'd0,  1, 0, 0);
      drive(1,1,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h06, 0, 4'd0,  1, 0, 1);
      drive(1,0,0,0,0,1,1,0,0, 32'h0, 32'h0);   expect_out(32'h00, 1, 4'd12, 1, 1, 0);
      drive(1,0,0,0,0,1,0,1,0, 32'h0, 32'h0);   expect_out(32'h04, 0, 4'd0,  0, 1, 0);
      drive(1,0,1,0,0,1,0,0,0, 32'h0, 32'h40);  expect_out(32'h08, 0, 4'd0,  1, 0, 1);
      drive(1,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h40, 0, 4'd0,  0, 1, 0);
      drive(1,1,1,0,0,1,0,0,0, 32'h20, 32'h80); expect_out(32'h44, 0, 4'd0,  1, 0, 1);
      drive(1,0,0,1,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h20, 0, 4'd0,  1, 1, 0);
      drive(1,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h20, 0, 4'd0,  0, 1, 0);
      drive(1,0,0,0,1,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h24, 0, 4'd0,  0, 1, 0);
      drive(1,0,0,0,0,0,0,0,0, 32'h0, 32'h0);   expect_out(32'h24, 0, 4'd0,  1, 1, 0);
      drive(1,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h24, 0, 4'd0,  0, 1, 0);
      drive(0,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h00, 0, 4'd0,  0, 1, 0);
      drive(1,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h00, 0, 4'd0,  0, 1, 0);
      drive(1,1,0,0,0,1,0,0,1, 32'hFFFF_FFFC, 32'h0); expect_out(32'h04, 0, 4'd0, 1, 0, 1);
      drive(1,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'hFFFF_FFFC, 0, 4'd0, 0, 1, 0);
      drive(1,0,0,0,0,1,0,0,0, 32'h0, 32'h0);   expect_out(32'h00, 0, 4'd0,  0, 1, 0);

      for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         n_total++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
